// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-only data memory.
// Sub-word stores are read-modify-write; loads are lane-extracted and extended.
module load_store_unit #(
    parameter int ADDRSIZE = 5,
    parameter int WORDSIZE = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [2:0]          req_funct3,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [31:0]         resp_rdata,
    output logic                resp_err,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RMW,
        S_RESP
    } state_t;

    state_t                r_state;
    logic                  r_write;
    logic [2:0]            r_funct3;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic                  r_resp_valid;
    logic [31:0]           r_resp_rdata;
    logic                  r_resp_err;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDRSIZE-1:0]   r_mem_addr;
    logic [31:0]           r_mem_wdata;

    logic                  w_err;
    logic                  w_is_sw;
    logic [31:0]           w_load;
    logic [31:0]           w_merge;

    function automatic logic f_err(
        input logic        wr,
        input logic [2:0]  f3,
        input logic [31:0] a
    );
        logic illegal;
        logic mis;
        logic oor;
        if (wr)
            illegal = (f3 > 3'b010);
        else
            illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        mis = ((f3[1:0] == 2'b01) && a[0])
           || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
        oor = |a[31:ADDRSIZE+2];
        return illegal || mis || oor;
    endfunction

    function automatic logic [31:0] f_extract(
        input logic [2:0]  f3,
        input logic [1:0]  a,
        input logic [31:0] w
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        unique case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = w;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] f_merge(
        input logic [2:0]  f3,
        input logic [1:0]  a,
        input logic [31:0] w,
        input logic [31:0] d
    );
        logic [31:0] res;
        res = w;
        if (f3[0])
            res[{a[1], 4'b0000} +: 16] = d[15:0];
        else
            res[{a, 3'b000} +: 8] = d[7:0];
        return res;
    endfunction

    assign w_err   = f_err(req_write, req_funct3, req_addr);
    assign w_is_sw = req_write && (req_funct3 == 3'b010);
    assign w_load  = f_extract(r_funct3, r_addr[1:0], mem_rdata);
    assign w_merge = f_merge(r_funct3, r_addr[1:0], mem_rdata, r_wdata);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write      <= req_write;
                        r_funct3     <= req_funct3;
                        r_addr       <= req_addr;
                        r_wdata      <= req_wdata;
                        r_mem_addr   <= req_addr[ADDRSIZE+1:2];
                        r_resp_rdata <= 32'd0;
                        if (w_err) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_state      <= S_RESP;
                        end else if (w_is_sw) begin
                            r_mem_write <= 1'b1;
                            r_mem_wdata <= req_wdata;
                            r_state     <= S_WR;
                        end else begin
                            r_mem_read <= 1'b1;
                            r_state    <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    r_mem_read <= 1'b0;
                    if (r_write) begin
                        // Sub-word store: splice the new lane into the word just read
                        r_mem_wdata <= w_merge;
                        r_mem_write <= 1'b1;
                        r_state     <= S_RMW;
                    end else begin
                        r_resp_rdata <= w_load;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_WR, S_RMW: begin
                    r_mem_write  <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= 32'd0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_mem_read   <= 1'b0;
                    r_mem_write  <= 1'b0;
                    r_resp_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule
